// File: rtl/shift_in_param.sv
// Serial-to-parallel operand capture. A rising edge on sx starts a WIDTH-bit word,
// which is held on x_parallel with fx high until ack.
module shift_in_param #(
    parameter int unsigned WIDTH      = 12,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          RESTART_EN = 1'b1,
    parameter int unsigned CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_in,
    input  logic             sx,
    input  logic             ack,
    output logic [WIDTH-1:0] x_parallel,
    output logic             fx,
    output logic             busy,
    output logic [CW-1:0]    bit_count
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StShifting = 2'b01,
        StDone     = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sx_q;
    logic             armed_q;
    logic             fx_q;
    logic             busy_q;
    logic             start;

    // armed_q blocks a start until sx has been seen low at least once after reset,
    // so sx already high at reset release does not count as an edge.
    assign start = sx & ~sx_q & armed_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShifting;
                    x_d     = '0;
                    cnt_d   = '0;
                end
            end
            StShifting: begin
                if (start && RESTART_EN) begin
                    x_d   = '0;
                    cnt_d = '0;
                end else begin
                    if (MSB_FIRST) begin
                        x_d = {x_q[WIDTH-2:0], x_in};
                    end else begin
                        x_d = {x_in, x_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // A new start takes priority over a simultaneous ack.
                if (start) begin
                    state_d = StShifting;
                    x_d     = '0;
                    cnt_d   = '0;
                end else if (ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            cnt_q   <= '0;
            sx_q    <= 1'b0;
            armed_q <= 1'b0;
            fx_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx;
            armed_q <= armed_q | ~sx;
            fx_q    <= (state_d == StDone);
            busy_q  <= (state_d == StShifting);
        end
    end

    assign x_parallel = x_q;
    assign fx         = fx_q;
    assign busy       = busy_q;
    assign bit_count  = cnt_q;

endmodule
